// File: rtl/us_sched_pkg.sv
// us_sched_pkg: shared states, header layout and field widths for the upstream flow scheduler
package us_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_HDR, S_READ, S_DRAIN, S_NEXT} state_t;
  localparam int CH_W = 8;
  localparam int CNT_W = 12;
  localparam int FRAME_W = 16;
  localparam logic [15:0] HDR_SYNC = 16'hEB90;
  localparam int HDR_SYNC_LSB = 112;
  localparam int HDR_FRAME_LSB = 96;
  localparam int HDR_CH_LSB = 88;
  localparam int HDR_LEN_LSB = 68;
endpackage

// File: rtl/us_sched_rd_pipe.sv
// us_sched_rd_pipe: channel data mux, two-stage read pipeline and header injection
module us_sched_rd_pipe import us_sched_pkg::*; #(
  parameter int TOTAL_NUM = 104
) (
  input  logic                       sys_clk_i,
  input  logic                       rst_i,
  input  logic                       rd_vld,
  input  logic [CH_W-1:0]            ch,
  input  logic [TOTAL_NUM*128-1:0]   cache_dout_i,
  input  logic                       hdr_vld,
  input  logic [127:0]               hdr_word,
  output logic                       flow_vld_o,
  output logic [127:0]               flow_data_o
);
  logic rd_q;
  logic [CH_W-1:0] ch_q;
  logic [127:0] dout_sel;
  always_comb begin
    dout_sel = '0;
    for (int i = 0; i < TOTAL_NUM; i++)
      if (ch_q == CH_W'(i)) dout_sel = cache_dout_i[i*128 +: 128];
  end
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      rd_q        <= 1'b0;
      ch_q        <= '0;
      flow_vld_o  <= 1'b0;
      flow_data_o <= '0;
    end else begin
      rd_q        <= rd_vld;
      ch_q        <= ch;
      flow_vld_o  <= hdr_vld | rd_q;
      flow_data_o <= hdr_vld ? hdr_word : rd_q ? dout_sel : '0;
    end
  end
endmodule

// File: rtl/us_flow_scheduler.sv
// us_flow_scheduler: time-slotted scheduler sharing one upstream flow port among channel caches
module us_flow_scheduler import us_sched_pkg::*; #(
  parameter int TOTAL_NUM     = 104,
  parameter int MAX_BURST     = 2048,
  parameter int EMPTY_TIMEOUT = 64
) (
  input  logic                       sys_clk_i,
  input  logic                       rst_i,
  input  logic                       time25ms_pluse_i,
  output logic [TOTAL_NUM-1:0]       cache_rd_en_o,
  input  logic [TOTAL_NUM*128-1:0]   cache_dout_i,
  input  logic [TOTAL_NUM-1:0]       cache_empty_i,
  input  logic [TOTAL_NUM*12-1:0]    cache_count_i,
  output logic                       flow_vld_o,
  output logic [127:0]               flow_data_o,
  input  logic                       flow_prog_full_i,
  output logic                       busy_o,
  output logic [FRAME_W-1:0]         frame_cnt_o,
  output logic [15:0]                overrun_cnt_o,
  output logic                       underflow_err_o
);
  state_t state;
  logic [CH_W-1:0] ch;
  logic [CNT_W-1:0] snap [TOTAL_NUM];
  logic [CNT_W-1:0] issued, cur_cnt, burst_len;
  logic [15:0] empty_cnt;
  logic cur_empty, rd, hdr_vld, drain_q;
  logic [127:0] hdr_word;
  assign busy_o = state != S_IDLE;
  always_comb begin
    cur_cnt   = '0;
    cur_empty = 1'b1;
    for (int i = 0; i < TOTAL_NUM; i++)
      if (ch == CH_W'(i)) begin
        cur_cnt   = snap[i];
        cur_empty = cache_empty_i[i];
      end
    burst_len = cur_cnt > CNT_W'(MAX_BURST) ? CNT_W'(MAX_BURST) : cur_cnt;
    rd        = state == S_READ && !flow_prog_full_i && !cur_empty && issued < burst_len;
    hdr_vld   = state == S_HDR && cur_cnt != '0 && !flow_prog_full_i;
    cache_rd_en_o = rd ? TOTAL_NUM'(1) << ch : '0;
    hdr_word = '0;
    hdr_word[HDR_SYNC_LSB +: 16]       = HDR_SYNC;
    hdr_word[HDR_FRAME_LSB +: FRAME_W] = frame_cnt_o;
    hdr_word[HDR_CH_LSB +: CH_W]       = ch;
    hdr_word[HDR_LEN_LSB +: CNT_W]     = burst_len;
  end
  always_ff @(posedge sys_clk_i) begin
    if (state == S_SNAP)
      for (int i = 0; i < TOTAL_NUM; i++) snap[i] <= cache_count_i[i*CNT_W +: CNT_W];
  end
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      ch              <= '0;
      issued          <= '0;
      empty_cnt       <= '0;
      drain_q         <= 1'b0;
      frame_cnt_o     <= '0;
      overrun_cnt_o   <= '0;
      underflow_err_o <= 1'b0;
    end else begin
      underflow_err_o <= 1'b0;
      if (time25ms_pluse_i && state != S_IDLE && overrun_cnt_o != 16'hFFFF)
        overrun_cnt_o <= overrun_cnt_o + 16'd1;
      case (state)
        S_IDLE: if (time25ms_pluse_i) state <= S_SNAP;
        S_SNAP: begin
          ch    <= '0;
          state <= S_HDR;
        end
        S_HDR: begin
          issued    <= '0;
          empty_cnt <= '0;
          drain_q   <= 1'b0;
          state     <= cur_cnt == '0 ? S_NEXT : hdr_vld ? S_READ : S_HDR;
        end
        S_READ: begin
          if (rd) issued <= issued + 1'b1;
          empty_cnt <= cur_empty ? empty_cnt + 16'd1 : '0;
          if (rd && issued == burst_len - 1'b1) state <= S_DRAIN;
          else if (cur_empty && empty_cnt == 16'(EMPTY_TIMEOUT - 1)) begin
            underflow_err_o <= 1'b1;
            state           <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) state <= S_NEXT;
        end
        S_NEXT: begin
          if (ch == CH_W'(TOTAL_NUM - 1)) begin
            frame_cnt_o <= frame_cnt_o + 1'b1;
            state       <= S_IDLE;
          end else begin
            ch    <= ch + 1'b1;
            state <= S_HDR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  us_sched_rd_pipe #(.TOTAL_NUM(TOTAL_NUM)) u_rd_pipe (
    .sys_clk_i    (sys_clk_i),
    .rst_i        (rst_i),
    .rd_vld       (rd),
    .ch           (ch),
    .cache_dout_i (cache_dout_i),
    .hdr_vld      (hdr_vld),
    .hdr_word     (hdr_word),
    .flow_vld_o   (flow_vld_o),
    .flow_data_o  (flow_data_o)
  );
endmodule

// File: tb/tb_us_flow_scheduler.sv
// tb_us_flow_scheduler: scoreboard bench with behavioural channel caches for us_flow_scheduler
module tb_us_flow_scheduler;
  localparam int N = 104;
  localparam int MB = 2048;
  logic sys_clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic tick = 1'b0;
  logic pf = 1'b0;
  logic [N-1:0] rd_en;
  logic [N-1:0] empty = '1;
  logic [N*128-1:0] dout;
  logic [N*12-1:0] count = '0;
  logic vld, uf, busy;
  logic [127:0] data;
  logic [15:0] frame_cnt, overrun_cnt;
  int checks = 0, failures = 0;
  int wr_cnt [N], rd_ptr [N], ovr [N], rd_total [N];
  logic [127:0] dout_r [N];
  logic [127:0] exp_q [$];
  int vld_total = 0, uf_total = 0, multi_hot = 0, exp_frame = 0;
  always #5 sys_clk_i = ~sys_clk_i;
  for (genvar g = 0; g < N; g++) begin : g_fifo
    assign dout[g*128 +: 128] = dout_r[g];
  end
  us_flow_scheduler dut (
    .sys_clk_i        (sys_clk_i),
    .rst_i            (rst_i),
    .time25ms_pluse_i (tick),
    .cache_rd_en_o    (rd_en),
    .cache_dout_i     (dout),
    .cache_empty_i    (empty),
    .cache_count_i    (count),
    .flow_vld_o       (vld),
    .flow_data_o      (data),
    .flow_prog_full_i (pf),
    .busy_o           (busy),
    .frame_cnt_o      (frame_cnt),
    .overrun_cnt_o    (overrun_cnt),
    .underflow_err_o  (uf)
  );
  function automatic logic [127:0] word(input int c, input int k);
    return {8'(c), 24'(k), 96'hC0FFEE};
  endfunction
  function automatic logic [127:0] hdr(input int c, input int len, input int f);
    return {16'hEB90, 16'(f), 8'(c), 8'h0, 12'(len), 68'h0};
  endfunction
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input int c, input int n);
    wr_cnt[c] += n;
  endtask
  task automatic do_tick();
    repeat (2) @(negedge sys_clk_i);
    for (int c = 0; c < N; c++) begin
      int sz, cnt, len;
      sz  = wr_cnt[c] - rd_ptr[c];
      cnt = sz + ovr[c] > 4095 ? 4095 : sz + ovr[c];
      if (cnt > 0) begin
        len = cnt > MB ? MB : cnt;
        exp_q.push_back(hdr(c, len, exp_frame));
        for (int k = 0; k < (len < sz ? len : sz); k++) exp_q.push_back(word(c, rd_ptr[c] + k));
      end
    end
    tick = 1'b1;
    @(negedge sys_clk_i);
    tick = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge sys_clk_i);
      n++;
    end
    check("idle_timeout", 128'(busy), 128'(0));
    repeat (4) @(negedge sys_clk_i);
    check("sb_left", 128'(exp_q.size()), 128'(0));
    exp_frame++;
    check("frame_cnt", 128'(frame_cnt), 128'(16'(exp_frame)));
  endtask
  task automatic wait_rd(input int c, input int target);
    int n = 0;
    while (rd_total[c] < target && n < 1000) begin
      @(negedge sys_clk_i);
      #1;
      n++;
    end
    check("rd_wait", 128'(rd_total[c] >= target), 128'(1));
  endtask
  initial begin
    int r0, v0, u0;
    for (int i = 0; i < N; i++) dout_r[i] = '0;
    fork
      forever begin
        @(posedge sys_clk_i);
        if (!$onehot0(rd_en)) multi_hot++;
        for (int i = 0; i < N; i++)
          if (rd_en[i] && wr_cnt[i] > rd_ptr[i]) begin
            dout_r[i] <= word(i, rd_ptr[i]);
            rd_ptr[i]++;
            rd_total[i]++;
          end
      end
      forever begin
        @(negedge sys_clk_i);
        for (int i = 0; i < N; i++) begin
          empty[i] = wr_cnt[i] == rd_ptr[i];
          count[i*12 +: 12] = 12'((wr_cnt[i] - rd_ptr[i] + ovr[i]) > 4095 ? 4095 : wr_cnt[i] - rd_ptr[i] + ovr[i]);
        end
        if (uf) uf_total++;
        if (vld) begin
          vld_total++;
          if (exp_q.size() == 0) check("sb_extra_word", data, '0);
          else check("sb_word", data, exp_q.pop_front());
        end
      end
    join_none
    repeat (3) @(negedge sys_clk_i);
    check("rst_vld", 128'(vld), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_frame", 128'(frame_cnt), 128'(0));
    check("rst_overrun", 128'(overrun_cnt), 128'(0));
    check("rst_rd_en", 128'(rd_en), 128'(0));
    check("rst_uf", 128'(uf), 128'(0));
    rst_i = 1'b0;
    push(0, 3);
    push(5, 1);
    v0 = vld_total;
    do_tick();
    wait_idle();
    check("t1_words", 128'(vld_total - v0), 128'(6));
    push(2, 4000);
    r0 = rd_total[2];
    do_tick();
    wait_idle();
    check("t2_rd_pulses", 128'(rd_total[2] - r0), 128'(2048));
    check("t2_left", 128'(wr_cnt[2] - rd_ptr[2]), 128'(1952));
    do_tick();
    wait_idle();
    check("t2_rest", 128'(wr_cnt[2] - rd_ptr[2]), 128'(0));
    push(1, 8);
    r0 = rd_total[1];
    do_tick();
    wait_rd(1, r0 + 3);
    pf = 1'b1;
    #1;
    check("t3_rd_drop", 128'(rd_en), 128'(0));
    v0 = vld_total;
    repeat (10) @(negedge sys_clk_i);
    #1;
    check("t3_inflight", 128'(vld_total - v0 <= 2), 128'(1));
    pf = 1'b0;
    wait_idle();
    check("t3_rd_total", 128'(rd_total[1] - r0), 128'(8));
    push(0, 2);
    do_tick();
    repeat (5) @(negedge sys_clk_i);
    tick = 1'b1;
    @(negedge sys_clk_i);
    tick = 1'b0;
    #1;
    check("t4_overrun", 128'(overrun_cnt), 128'(1));
    check("t4_busy", 128'(busy), 128'(1));
    wait_idle();
    check("t4_overrun_end", 128'(overrun_cnt), 128'(1));
    push(3, 2);
    ovr[3] = 3;
    push(4, 1);
    u0 = uf_total;
    do_tick();
    wait_idle();
    ovr[3] = 0;
    check("t5_underflow", 128'(uf_total - u0), 128'(1));
    check("t5_ch4_read", 128'(wr_cnt[4] - rd_ptr[4]), 128'(0));
    push(0, 20);
    r0 = rd_total[0];
    do_tick();
    wait_rd(0, r0 + 3);
    rst_i = 1'b1;
    @(negedge sys_clk_i);
    #1;
    check("t6_rd_en", 128'(rd_en), 128'(0));
    check("t6_vld", 128'(vld), 128'(0));
    check("t6_frame", 128'(frame_cnt), 128'(0));
    check("t6_busy", 128'(busy), 128'(0));
    rst_i = 1'b0;
    exp_q.delete();
    exp_frame = 0;
    do_tick();
    wait_idle();
    check("t6_drained", 128'(wr_cnt[0] - rd_ptr[0]), 128'(0));
    check("onehot_rd_en", 128'(multi_hot), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/us_flow_scheduler.md
Name: us_flow_scheduler

Overview:
- Time-slotted scheduler that shares one 128-bit upstream flow port among TOTAL_NUM per-channel timing caches (standard-mode FIFOs).
- On each 25 ms tick it snapshots every cache fill count. It then visits channels 0..TOTAL_NUM-1 in order and, for each non-empty channel, emits one header word followed by that channel's burst.
- Honours downstream prog_full backpressure and reports frame and overrun statistics.
- Sits between the per-channel cache FIFOs and the upstream packer FIFO.

Parameters:
- TOTAL_NUM, 104, number of channel caches (≤ 256).
- MAX_BURST, 2048, maximum data words read from one channel per frame (≤ 4095).
- EMPTY_TIMEOUT, 64, consecutive cycles a selected cache may stay empty mid-burst before the burst is aborted.

Ports:
- sys_clk_i  in  1  single system clock.
- rst_i  in  1  synchronous, active-high reset.
- time25ms_pluse_i  in  1  one-cycle frame tick.
- cache_rd_en_o  out  TOTAL_NUM  per-channel FIFO read enable, one-hot or zero.
- cache_dout_i  in  TOTAL_NUM*128  per-channel FIFO data; channel i occupies [i*128 +: 128]; valid 1 cycle after rd_en.
- cache_empty_i  in  TOTAL_NUM  per-channel FIFO empty.
- cache_count_i  in  TOTAL_NUM*12  per-channel FIFO data count; channel i occupies [i*12 +: 12].
- flow_vld_o  out  1  output word valid.
- flow_data_o  out  128  output word.
- flow_prog_full_i  in  1  downstream programmable-full.
- busy_o  out  1  high when not in IDLE.
- frame_cnt_o  out  16  completed frames, wraps.
- overrun_cnt_o  out  16  ticks dropped while busy, saturates at 16'hFFFF.
- underflow_err_o  out  1  one-cycle pulse on burst abort.

Behaviour:
- Reset (rst_i sampled high at a clock edge): all outputs 0, state IDLE, all counters 0. Reset mid-burst drops rd_en on that edge; in-flight words are discarded and flow_vld_o is 0 from that edge.
- States: IDLE, SNAP, HDR, READ, DRAIN, NEXT.
- IDLE→SNAP on time25ms_pluse_i.
- SNAP (1 cycle): latch all counts; ch=0; →HDR.
- HDR:
  - If snap_count[ch]==0, →NEXT with no header emitted.
  - Else, if !flow_prog_full_i, emit one header word with flow_vld_o=1 the next cycle, then →READ; otherwise wait in HDR.
  - burst_len = min(snap_count[ch], MAX_BURST).
- Header word layout: [127:112]=16'hEB90, [111:96]=frame_cnt_o, [95:88]=ch, [87:80]=0, [79:68]=burst_len, [67:0]=0.
- READ:
  - cache_rd_en_o[ch] = !flow_prog_full_i & !cache_empty_i[ch] & (issued < burst_len).
  - Combinational from state, count and inputs. Never asserted for channels other than ch.
  - When issued==burst_len, →DRAIN.
- Empty timeout: if cache_empty_i[ch] is high for EMPTY_TIMEOUT consecutive cycles in READ, pulse underflow_err_o and →DRAIN. The header's burst_len is then not corrected.
- Read pipeline latency: rd_en at cycle t, dout registered into flow_data_o, flow_vld_o=1 at t+2. One word per cycle sustained.
- DRAIN: wait 2 cycles for the pipeline to empty, then →NEXT.
- NEXT:
  - If ch==TOTAL_NUM-1: frame_cnt_o += 1 (16-bit wrap) and →IDLE.
  - Else ch += 1 and →HDR.
  - Zero-count channels cost 2 cycles each (HDR plus NEXT).
- A frame in which every channel count is 0 still increments frame_cnt_o.
- Backpressure: prog_full is honoured on the same cycle. At most 2 words are in flight after prog_full rises; the downstream threshold must leave ≥3 words headroom.
- Overrun: a tick while state≠IDLE, including the NEXT→IDLE cycle, increments overrun_cnt_o (saturating) and is otherwise ignored.
- Snapshot counts only under-estimate the FIFO contents (caches are written only), so an empty cache mid-burst is abnormal and handled by the timeout.

Decomposition:
- Package us_sched_pkg:
  - state enum;
  - header sync constant 16'hEB90;
  - header field offsets;
  - width constants for ch (8), count (12), frame (16).
- One sub-module, us_sched_rd_pipe: channel dout mux plus the two-stage valid/data pipeline and header injection. The main block keeps the FSM, snapshot and counters.

Test Plan:
- Counts ch0=3, ch5=1, others 0; one tick → exactly 6 output words: header(ch0,len3), 3 data, header(ch5,len1), 1 data. frame_cnt_o=1.
- ch2 count 4000 with MAX_BURST=2048 → header len=2048, exactly 2048 rd_en pulses on ch2; the remainder is left in the FIFO.
- ch1 count 8; prog_full held high for 10 cycles starting mid-burst → rd_en drops the same cycle, ≤2 extra valid words, all 8 words delivered in order with no duplicates.
- Second tick 5 cycles after the first → overrun_cnt_o=1, busy_o stays 1, still exactly one frame completed.
- ch3 snapshot count 5 but only 2 words present → 2 data words out, underflow_err_o pulse after 64 empty cycles, scheduler proceeds to ch4.
- Assert rst_i mid-READ on ch0 → next cycle all cache_rd_en_o=0, flow_vld_o=0, frame_cnt_o=0; a new tick restarts the frame at ch0.
